// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// inst_sram_axi_rd_bridge_pkg: shared AXI read constants, default instruction ARID and SRAM size codes
package inst_sram_axi_rd_bridge_pkg;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [7:0] LEN_SINGLE    = 8'd0;
    localparam logic [1:0] LOCK_DEFAULT  = 2'd0;
    localparam logic [3:0] CACHE_DEFAULT = 4'd0;
    localparam logic [2:0] PROT_DEFAULT  = 3'd0;
    localparam logic [3:0] INST_ARID     = 4'd0;
    localparam logic [1:0] SIZE_BYTE     = 2'b00;
    localparam logic [1:0] SIZE_HALF     = 2'b01;
    localparam logic [1:0] SIZE_WORD     = 2'b10;
endpackage

// File: rtl/axi_ar_slot.sv
// axi_ar_slot: single-entry AR holding register with valid/ready
// Ports: load_i/addr_i/size_i capture a new request (caller loads only when valid_o is low);
//        ready_i is the AXI arready; valid_o/addr_o/size_o drive the AR channel.
module axi_ar_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] addr_i,
    input  logic [2:0]  size_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] addr_o,
    output logic [2:0]  size_o
);
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;

    always_comb begin
        valid_d = load_i | (valid_q & ~ready_i);
        addr_d  = load_i ? addr_i : addr_q;
        size_d  = load_i ? size_i : size_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign size_o  = size_q;
endmodule

// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge: SRAM-like instruction fetch port to single-beat in-order AXI4 reads
// Ports: sram_* is the fetch-side request/response handshake (write fields ignored);
//        ar*/r* are the AXI4 read address and read data channels toward memory.
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ARID        = INST_ARID
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [31:0] sram_addr,
    input  logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_ok;

    // Only one AR may be pending: a new request waits until the slot has drained.
    assign sram_addr_ok = sram_req & ~arvalid & (cnt_q < CNT_MAX) & ~reset;
    assign rready       = cnt_q != '0;
    assign sram_data_ok = rvalid & rready;
    assign sram_rdata   = rdata;

    always_comb begin
        cnt_d = (sram_addr_ok & ~sram_data_ok) ? cnt_q + CW'(1) :
                (sram_data_ok & ~sram_addr_ok) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    axi_ar_slot u_ar_slot (
        .clk     (clk),
        .reset   (reset),
        .load_i  (sram_addr_ok),
        .addr_i  (sram_addr),
        .size_i  ({1'b0, sram_size}),
        .ready_i (arready),
        .valid_o (arvalid),
        .addr_o  (araddr),
        .size_o  (arsize)
    );

    assign arid    = AXI_ARID;
    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_DEFAULT;
    assign arcache = CACHE_DEFAULT;
    assign arprot  = PROT_DEFAULT;

    // Write-side fields and R sideband carry no meaning for in-order single-beat instruction reads.
    assign unused_ok = ^{sram_wr, sram_wstrb, sram_wdata, rid, rresp, rlast};
endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// tb_inst_sram_axi_rd_bridge: vector table, corner sequences and randomized model check of the bridge
module tb_inst_sram_axi_rd_bridge;
    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock, rresp;
    logic [3:0]  arcache;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_chk = 0;
    int n_fail = 0;

    inst_sram_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .AXI_ARID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          ardy;
        bit          rv;
        logic [31:0] rd;
        bit          e_ok;
        bit          e_arv;
        logic [31:0] e_addr;
        bit          e_rr;
        bit          e_dok;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input bit req, input logic [31:0] addr, input bit ardy,
                         input bit rv, input logic [31:0] rd);
        sram_req  = req;
        sram_addr = addr;
        sram_size = 2'b10;
        arready   = ardy;
        rvalid    = rv;
        rdata     = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: accepted-but-not-handshaken ARs and accepted-but-not-returned reads.
    logic [34:0] ar_pend[$];
    logic [31:0] inflight[$];

    initial begin
        reset = 1'b1;
        sram_wr = 1'b0; sram_wstrb = '0; sram_wdata = '0;
        rid = '0; rresp = '0; rlast = 1'b1;
        drive(1, 32'h1c000000, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_arvalid", 32'(arvalid), 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_arsize", 32'(arsize), 0);
        chk("reset_rready", 32'(rready), 0);
        chk("reset_addr_ok", 32'(sram_addr_ok), 0);
        chk("const_arid", 32'(arid), 0);
        chk("const_arlen", 32'(arlen), 0);
        chk("const_arburst", 32'(arburst), 1);
        chk("const_arlock", 32'(arlock), 0);
        chk("const_arcache", 32'(arcache), 0);
        chk("const_arprot", 32'(arprot), 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();

        // Single fetch, stray R beat, then overlapping reads with a same-cycle accept/return.
        tbl[0]  = '{1, 32'h1c000000, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0};
        tbl[1]  = '{0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h1c000000, 1, 0};
        tbl[2]  = '{0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 0};
        tbl[3]  = '{0, 32'h0,        0, 1, 32'h02800c0c, 0, 0, 32'h0,        1, 1};
        tbl[4]  = '{0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        tbl[5]  = '{0, 32'h0,        0, 1, 32'hdeadbeef, 0, 0, 32'h0,        0, 0};
        tbl[6]  = '{1, 32'h1c000010, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0};
        tbl[7]  = '{0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h1c000010, 1, 0};
        tbl[8]  = '{1, 32'h1c000014, 0, 0, 32'h0,        1, 0, 32'h0,        1, 0};
        tbl[9]  = '{0, 32'h0,        1, 1, 32'haaaa0000, 0, 1, 32'h1c000014, 1, 1};
        tbl[10] = '{1, 32'h1c000018, 0, 1, 32'hbbbb0000, 1, 0, 32'h0,        1, 1};
        tbl[11] = '{0, 32'h0,        0, 0, 32'h0,        0, 1, 32'h1c000018, 1, 0};
        tbl[12] = '{0, 32'h0,        1, 0, 32'h0,        0, 1, 32'h1c000018, 1, 0};
        tbl[13] = '{0, 32'h0,        0, 1, 32'h12345678, 0, 0, 32'h0,        1, 1};
        tbl[14] = '{0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].addr, tbl[i].ardy, tbl[i].rv, tbl[i].rd);
            chk($sformatf("vec%0d_addr_ok", i), 32'(sram_addr_ok), 32'(tbl[i].e_ok));
            chk($sformatf("vec%0d_arvalid", i), 32'(arvalid), 32'(tbl[i].e_arv));
            chk($sformatf("vec%0d_rready", i), 32'(rready), 32'(tbl[i].e_rr));
            chk($sformatf("vec%0d_data_ok", i), 32'(sram_data_ok), 32'(tbl[i].e_dok));
            if (tbl[i].e_arv) begin
                chk($sformatf("vec%0d_araddr", i), araddr, tbl[i].e_addr);
                chk($sformatf("vec%0d_arsize", i), 32'(arsize), 32'h2);
            end
            if (tbl[i].e_dok) chk($sformatf("vec%0d_rdata", i), sram_rdata, tbl[i].rd);
            tick();
        end

        // AR backpressure: five stalled cycles, then handshake.
        drive(1, 32'h1c000020, 0, 0, 0);
        chk("bp_accept", 32'(sram_addr_ok), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h1c000024, 0, 0, 0);
            chk("bp_arvalid", 32'(arvalid), 1);
            chk("bp_araddr", araddr, 32'h1c000020);
            chk("bp_addr_ok", 32'(sram_addr_ok), 0);
            tick();
        end
        drive(1, 32'h1c000024, 1, 0, 0);
        chk("bp_hs_arvalid", 32'(arvalid), 1);
        chk("bp_hs_addr_ok", 32'(sram_addr_ok), 0);
        tick();
        drive(1, 32'h1c000024, 0, 0, 0);
        chk("bp_after_arvalid", 32'(arvalid), 0);
        chk("bp_after_addr_ok", 32'(sram_addr_ok), 1);
        tick();
        drive(0, 0, 1, 0, 0);
        chk("bp_second_araddr", araddr, 32'h1c000024);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 32'h50000000 + 32'(i));
            chk("bp_drain_dok", 32'(sram_data_ok), 1);
            tick();
        end

        // Outstanding limit with R withheld.
        drive(1, 32'h1c000000, 0, 0, 0);
        chk("lim_acc0", 32'(sram_addr_ok), 1);
        tick();
        drive(1, 32'h1c000004, 1, 0, 0);
        chk("lim_busy", 32'(sram_addr_ok), 0);
        tick();
        drive(1, 32'h1c000004, 0, 0, 0);
        chk("lim_acc1", 32'(sram_addr_ok), 1);
        tick();
        drive(1, 32'h1c000008, 1, 0, 0);
        chk("lim_araddr1", araddr, 32'h1c000004);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1c000008, 0, 0, 0);
            chk("lim_full_addr_ok", 32'(sram_addr_ok), 0);
            chk("lim_full_arvalid", 32'(arvalid), 0);
            tick();
        end
        drive(1, 32'h1c000008, 0, 1, 32'h11110000);
        chk("lim_ret_dok", 32'(sram_data_ok), 1);
        chk("lim_ret_addr_ok", 32'(sram_addr_ok), 0);
        tick();
        drive(1, 32'h1c000008, 0, 0, 0);
        chk("lim_acc2", 32'(sram_addr_ok), 1);
        tick();

        // Reset with an AR pending and two reads in flight.
        drive(0, 0, 0, 0, 0);
        chk("rst_pre_arvalid", 32'(arvalid), 1);
        chk("rst_pre_araddr", araddr, 32'h1c000008);
        reset = 1'b1;
        drive(1, 32'h1c000040, 0, 0, 0);
        chk("rst_addr_ok", 32'(sram_addr_ok), 0);
        tick();
        drive(1, 32'h1c000040, 0, 1, 32'h77777777);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rready", 32'(rready), 0);
        chk("rst_dok", 32'(sram_data_ok), 0);
        chk("rst_addr_ok2", 32'(sram_addr_ok), 0);
        reset = 1'b0;
        drive(0, 0, 0, 1, 32'h77777777);
        chk("post_rst_rready", 32'(rready), 0);
        chk("post_rst_dok", 32'(sram_data_ok), 0);
        tick();
        drive(1, 32'h1c000100, 0, 0, 0);
        chk("post_rst_acc", 32'(sram_addr_ok), 1);
        tick();
        drive(0, 0, 1, 0, 0);
        chk("post_rst_araddr", araddr, 32'h1c000100);
        tick();
        drive(0, 0, 0, 1, 32'hcafef00d);
        chk("post_rst_dok2", 32'(sram_data_ok), 1);
        chk("post_rst_rdata", sram_rdata, 32'hcafef00d);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("post_rst_idle", 32'(rready), 0);

        // Randomized traffic against the queue model.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ar_pend.delete();
        inflight.delete();
        for (int c = 0; c < 3000; c++) begin
            bit          req, ardy, rv, e_ok, e_arv, e_rr, e_dok;
            logic [31:0] a, d;
            req  = ($urandom % 3) != 0;
            a    = $urandom & 32'hfffffffc;
            ardy = $urandom % 2;
            rv   = ($urandom % 3) == 0;
            d    = $urandom;
            sram_wr = $urandom % 2; sram_wstrb = 4'($urandom); sram_wdata = $urandom;
            rid = 4'($urandom); rresp = 2'($urandom); rlast = $urandom % 2;
            drive(req, a, ardy, rv, d);
            sram_size = 2'($urandom % 3);
            #1;
            e_ok  = req && ar_pend.size() == 0 && inflight.size() < MAX;
            e_arv = ar_pend.size() != 0;
            e_rr  = inflight.size() != 0;
            e_dok = rv && e_rr;
            chk("rnd_addr_ok", 32'(sram_addr_ok), 32'(e_ok));
            chk("rnd_arvalid", 32'(arvalid), 32'(e_arv));
            chk("rnd_rready", 32'(rready), 32'(e_rr));
            chk("rnd_data_ok", 32'(sram_data_ok), 32'(e_dok));
            if (e_arv) begin
                chk("rnd_araddr", araddr, ar_pend[0][31:0]);
                chk("rnd_arsize", 32'(arsize), 32'(ar_pend[0][34:32]));
            end
            if (e_dok) begin
                chk("rnd_rdata", sram_rdata, d);
                void'(inflight.pop_front());
            end
            if (e_arv && ardy) void'(ar_pend.pop_front());
            if (e_ok) begin
                ar_pend.push_back({1'b0, sram_size, a});
                inflight.push_back(a);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
- Sits directly upstream of the fetch stage, on its instruction-memory port.
- Accepts the SRAM-like handshake (req / addr_ok / data_ok / rdata) and turns each request into a single-beat AXI4 read (AR/R channels) toward the memory subsystem.
- Supports a bounded number of in-order outstanding reads.
- Returns every accepted request's data in issue order. Fetch-side cancellation, discarding stale data, is handled by the consumer; this block never drops a response.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned requests (1..3).
- AXI_ARID, 4'd0, constant ID driven on arid for all instruction reads.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sram_req  in  1  request valid from fetch
- sram_wr  in  1  write flag; ignored, fetch ties to 0
- sram_size  in  2  log2 bytes (2'b10 = word)
- sram_addr  in  32  physical byte address
- sram_wstrb  in  4  ignored
- sram_wdata  in  32  ignored
- sram_addr_ok  out  1  request accepted this cycle
- sram_data_ok  out  1  read data valid this cycle
- sram_rdata  out  32  read data
- arid  out  4  AXI_ARID
- araddr  out  32  read address
- arlen  out  8  constant 0 (single beat)
- arsize  out  3  {1'b0, sram_size}
- arburst  out  2  constant INCR (2'b01)
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored (single ID, in-order)
- rdata  in  32  read data
- rresp  in  2  ignored
- rlast  in  1  ignored (arlen = 0)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: arvalid = 0, araddr = 0, arsize = 0, outstanding count = 0, sram_addr_ok = 0, rready = 0.
  - Reset mid-operation abandons all in-flight transactions.
  - Any R beats arriving after reset are not acknowledged until the count logic re-enables rready.
- State:
  - AR holding register: ar_busy (= arvalid), araddr, arsize.
  - Counter cnt, width $clog2(MAX_OUTSTANDING+1).
- Accept rule: sram_addr_ok = sram_req & ~ar_busy & (cnt < MAX_OUTSTANDING).
  - Purely combinational from registers and sram_req.
  - Never asserted during reset.
- Accept (sram_req & sram_addr_ok at cycle T):
  - latch araddr <= sram_addr, arsize <= {1'b0, sram_size};
  - arvalid = 1 from T+1.
- AR handshake:
  - arvalid and the latched fields hold stable until arvalid & arready.
  - arvalid drops the cycle after the handshake.
  - Earliest next accept is the cycle after arvalid falls, so at most one AR is pending.
- R channel:
  - rready = (cnt != 0), registered-state based.
  - sram_data_ok = rvalid & rready.
  - sram_rdata = rdata, combinational pass-through.
  - Latency: data_ok asserts in the same cycle as the R beat. Minimum is accept at T, arready at T+1, data_ok at T+2.
- Counter:
  - +1 on accept, −1 on data_ok, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING, never underflows.
  - An R beat with cnt == 0 is not accepted (rready = 0).
- Ordering: responses are forwarded strictly in AXI arrival order, which equals issue order under the single ID.
- sram_wr, wstrb, wdata, rid, rresp and rlast have no effect on behaviour.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR, LEN_SINGLE, CACHE_DEFAULT, PROT_DEFAULT;
  - the default instruction ARID;
  - the SRAM size-code encodings.
- One natural sub-module, axi_ar_slot: a single-entry AR holding register with valid/ready. Reused later by the data-side bridge.
- The counter stays inline.

Test Plan:
- Single fetch: req with addr 0x1c000000, size 2'b10 → addr_ok at T; arvalid at T+1 with araddr 0x1c000000, arsize 3'b010, arlen 0, arburst 01; arready at T+1; rvalid with rdata 0x02800c0c at T+3 → data_ok and sram_rdata 0x02800c0c at T+3; cnt returns to 0.
- AR backpressure: arready held 0 for 5 cycles → arvalid and araddr stable all 5 cycles; addr_ok = 0 throughout despite req = 1; handshake on cycle 6.
- Outstanding limit: MAX_OUTSTANDING = 2, three back-to-back reqs to 0x1c000000, 0x1c000004, 0x1c000008 with rvalid withheld → third addr_ok stays 0 until the first data_ok; then it is accepted.
- Ordering: two reads, R beats 0xAAAA0000 then 0xBBBB0000 → data_ok pulses deliver them in that order.
- Simultaneous events: data_ok in the same cycle as a new accept with cnt = 1 → cnt stays 1; unexpected rvalid with cnt = 0 → rready = 0, no data_ok.
- Reset mid-flight: reset asserted while arvalid = 1 and cnt = 2 → next cycle arvalid = 0, cnt = 0, addr_ok = 0 during reset; a normal fetch succeeds after deassertion.
